// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 work feeder and the downstream nonce checker.
package sha256_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned MID_WORDS  = 8;
  localparam int unsigned TAIL_WORDS = 3;
  localparam int unsigned MID_W      = MID_WORDS * WORD_W;

  localparam logic [WORD_W-1:0] PAD_ONE_WORD    = 32'h8000_0000;
  localparam logic [WORD_W-1:0] PAD_LEN_DEFAULT = 32'h0000_0280;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  // midstate[i] is init_i, tail[i] is chunk word i.
  typedef struct packed {
    logic [MID_WORDS-1:0][WORD_W-1:0]  midstate;
    logic [TAIL_WORDS-1:0][WORD_W-1:0] tail;
    logic [WORD_W-1:0]                 nonce_start;
    logic [WORD_W-1:0]                 nonce_end;
  } job_t;

  // Build a job from the flat port view; the flat midstate has init_0 in its top word.
  function automatic job_t pack_job(input logic [MID_W-1:0]  mid,
                                    input logic [WORD_W-1:0] w0,
                                    input logic [WORD_W-1:0] w1,
                                    input logic [WORD_W-1:0] w2,
                                    input logic [WORD_W-1:0] ns,
                                    input logic [WORD_W-1:0] ne);
    job_t j;
    for (int i = 0; i < int'(MID_WORDS); i++) begin
      j.midstate[i] = mid[MID_W-1-WORD_W*i -: WORD_W];
    end
    j.tail[0]     = w0;
    j.tail[1]     = w1;
    j.tail[2]     = w2;
    j.nonce_start = ns;
    j.nonce_end   = ne;
    return j;
  endfunction

endpackage

// File: rtl/sha256_nonce_ctr.sv
// Nonce sweep counter: current nonce, 33-bit step add, last/wrap detection, throttle hold.
module sha256_nonce_ctr
  import sha256_pkg::*;
#(
  parameter int unsigned NONCE_STEP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] load_start,
  input  logic [WORD_W-1:0] load_end,
  input  logic              run,
  input  logic              en,
  output logic [WORD_W-1:0] cur,
  output logic              issue_c,
  output logic              last_c,
  output logic              empty_c
);

  logic [WORD_W-1:0] end_q;
  logic [WORD_W:0]   sum_c;

  assign sum_c = {1'b0, cur} + (WORD_W+1)'(NONCE_STEP);

  // cur only exceeds the end when the range was empty from the start.
  assign empty_c = cur > end_q;
  assign last_c  = sum_c[WORD_W] || (sum_c[WORD_W-1:0] > end_q);
  assign issue_c = run && en && !empty_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur   <= '0;
      end_q <= '0;
    end else if (load) begin
      cur   <= load_start;
      end_q <= load_end;
    end else if (issue_c && !last_c) begin
      cur <= sum_c[WORD_W-1:0];
    end
  end

endmodule

// File: rtl/sha256_work_feeder.sv
// Job feeder for the SHA-256 pipeline: issues one padded second chunk per clock while sweeping the nonce.
// Optional one-deep job queue with no-bubble handoff: define SHA256_FEEDER_JOB_QUEUE_EN.
module sha256_work_feeder
  import sha256_pkg::*;
#(
  parameter int unsigned NONCE_STEP   = 1,
  parameter logic [31:0] PAD_LEN_WORD = PAD_LEN_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [255:0] job_midstate,
  input  logic [31:0]  job_merkle_tail,
  input  logic [31:0]  job_time,
  input  logic [31:0]  job_bits,
  input  logic [31:0]  job_nonce_start,
  input  logic [31:0]  job_nonce_end,
  input  logic         en,
  input  logic         abort,
  output logic         valid_o,
  output logic [31:0]  init_0,
  output logic [31:0]  init_1,
  output logic [31:0]  init_2,
  output logic [31:0]  init_3,
  output logic [31:0]  init_4,
  output logic [31:0]  init_5,
  output logic [31:0]  init_6,
  output logic [31:0]  init_7,
  output logic [31:0]  chunk_0,
  output logic [31:0]  chunk_1,
  output logic [31:0]  chunk_2,
  output logic [31:0]  chunk_3,
  output logic [31:0]  chunk_4,
  output logic [31:0]  chunk_5,
  output logic [31:0]  chunk_6,
  output logic [31:0]  chunk_7,
  output logic [31:0]  chunk_8,
  output logic [31:0]  chunk_9,
  output logic [31:0]  chunk_10,
  output logic [31:0]  chunk_11,
  output logic [31:0]  chunk_12,
  output logic [31:0]  chunk_13,
  output logic [31:0]  chunk_14,
  output logic [31:0]  chunk_15,
  output logic [31:0]  nonce_o,
  output logic         done_o,
  output logic         aborted_o,
  output logic [63:0]  issued_cnt
);

  state_e            state;
  job_t              job_in_c;
  job_t              nxt_job_c;
  logic              accept_c;
  logic              nxt_avail_c;
  logic              load_c;
  logic              run_c;
  logic              ctr_issue_c;
  logic              ctr_last_c;
  logic              ctr_empty_c;
  logic [WORD_W-1:0] cur;
  logic              abort_q;
  logic              handoff_q;

  assign job_in_c = pack_job(job_midstate, job_merkle_tail, job_time, job_bits,
                             job_nonce_start, job_nonce_end);
  assign accept_c = job_valid && job_ready;
  assign run_c    = (state == RUN) && !abort;

`ifdef SHA256_FEEDER_JOB_QUEUE_EN
  job_t shadow_q;
  logic shadow_full;

  // A queued job wins over a fresh offer; a fresh offer bypasses the shadow when a load is due.
  assign nxt_avail_c = shadow_full || accept_c;
  assign nxt_job_c   = shadow_full ? shadow_q : job_in_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q    <= '0;
      shadow_full <= 1'b0;
      job_ready   <= 1'b0;
    end else if (load_c) begin
      shadow_full <= 1'b0;
      job_ready   <= 1'b1;
    end else if (accept_c) begin
      shadow_q    <= job_in_c;
      shadow_full <= 1'b1;
      job_ready   <= 1'b0;
    end else begin
      job_ready <= !shadow_full;
    end
  end
`else
  logic idle_nxt_c;

  assign nxt_avail_c = accept_c;
  assign nxt_job_c   = job_in_c;
  assign idle_nxt_c  = (state != RUN) && !load_c;

  always_ff @(posedge clk) begin
    if (!rst_n) job_ready <= 1'b0;
    else        job_ready <= idle_nxt_c;
  end
`endif

  // Start a job from IDLE, hand off on the last issue, or pick up a waiting job after FINISH.
  always_comb begin
    load_c = 1'b0;
    case (state)
      IDLE:    load_c = nxt_avail_c;
      RUN:     load_c = ctr_issue_c && ctr_last_c && nxt_avail_c;
      FINISH:  load_c = nxt_avail_c;
      default: load_c = 1'b0;
    endcase
  end

  sha256_nonce_ctr #(
    .NONCE_STEP (NONCE_STEP)
  ) u_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_c),
    .load_start (nxt_job_c.nonce_start),
    .load_end   (nxt_job_c.nonce_end),
    .run        (run_c),
    .en         (en),
    .cur        (cur),
    .issue_c    (ctr_issue_c),
    .last_c     (ctr_last_c),
    .empty_c    (ctr_empty_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      valid_o    <= 1'b0;
      done_o     <= 1'b0;
      aborted_o  <= 1'b0;
      abort_q    <= 1'b0;
      handoff_q  <= 1'b0;
      issued_cnt <= '0;
      nonce_o    <= '0;
      chunk_0    <= '0;
      chunk_1    <= '0;
      chunk_2    <= '0;
      chunk_3    <= '0;
      chunk_4    <= '0;
      chunk_15   <= '0;
      init_0     <= '0;
      init_1     <= '0;
      init_2     <= '0;
      init_3     <= '0;
      init_4     <= '0;
      init_5     <= '0;
      init_6     <= '0;
      init_7     <= '0;
    end else begin
      valid_o   <= 1'b0;
      handoff_q <= 1'b0;
      // done follows FINISH by one cycle, or lands with the first issue of a handed-off job.
      done_o    <= (state == FINISH) || handoff_q;
      aborted_o <= (state == FINISH) && abort_q;

      case (state)
        IDLE: begin
          if (load_c) state <= RUN;
        end
        RUN: begin
          if (abort) begin
            state   <= FINISH;
            abort_q <= 1'b1;
          end else if (ctr_empty_c) begin
            state <= FINISH;
          end else if (ctr_issue_c) begin
            valid_o    <= 1'b1;
            nonce_o    <= cur;
            chunk_3    <= cur;
            issued_cnt <= issued_cnt + 64'd1;
            if (ctr_last_c) begin
              state     <= load_c ? RUN : FINISH;
              handoff_q <= load_c;
            end
          end
        end
        FINISH: begin
          state <= load_c ? RUN : IDLE;
        end
        default: state <= IDLE;
      endcase

      if (load_c) begin
        abort_q  <= 1'b0;
        init_0   <= nxt_job_c.midstate[0];
        init_1   <= nxt_job_c.midstate[1];
        init_2   <= nxt_job_c.midstate[2];
        init_3   <= nxt_job_c.midstate[3];
        init_4   <= nxt_job_c.midstate[4];
        init_5   <= nxt_job_c.midstate[5];
        init_6   <= nxt_job_c.midstate[6];
        init_7   <= nxt_job_c.midstate[7];
        chunk_0  <= nxt_job_c.tail[0];
        chunk_1  <= nxt_job_c.tail[1];
        chunk_2  <= nxt_job_c.tail[2];
        chunk_4  <= PAD_ONE_WORD;
        chunk_15 <= PAD_LEN_WORD;
      end
    end
  end

  // Zero padding words never change.
  assign chunk_5  = '0;
  assign chunk_6  = '0;
  assign chunk_7  = '0;
  assign chunk_8  = '0;
  assign chunk_9  = '0;
  assign chunk_10 = '0;
  assign chunk_11 = '0;
  assign chunk_12 = '0;
  assign chunk_13 = '0;
  assign chunk_14 = '0;

endmodule

// File: tb/tb_sha256_work_feeder.sv
// Self-checking bench for sha256_work_feeder: directed vector table, corner sequences, random jobs vs a range model.
module tb_sha256_work_feeder;

  typedef struct {
    logic [31:0] start;
    logic [31:0] stop;
    int          n_exp;
    logic [31:0] first;
    logic [31:0] last;
    int          done_k;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n, job_valid, en, abort;
  logic [255:0] job_midstate;
  logic [31:0]  job_merkle_tail, job_time, job_bits, job_nonce_start, job_nonce_end;

  logic         job_ready, valid_o, done_o, aborted_o;
  logic [31:0]  nonce_o;
  logic [63:0]  issued_cnt;
  logic [31:0]  init_w [8];
  logic [31:0]  chunk_w [16];

  logic         r4, v4, d4, a4;
  logic [31:0]  n4;
  logic [63:0]  cnt4;
  logic [31:0]  i4 [8];
  logic [31:0]  c4 [16];

  logic         sel4 = 1'b0;
  logic         o_v, o_d, o_a;
  logic [31:0]  o_n;

  int checks   = 0;
  int failures = 0;

  logic [31:0] got_q [$];
  int          done_k_q [$];
  int          first_k;

  always #5 clk = ~clk;

  always_comb begin
    o_v = sel4 ? v4 : valid_o;
    o_d = sel4 ? d4 : done_o;
    o_a = sel4 ? a4 : aborted_o;
    o_n = sel4 ? n4 : nonce_o;
  end

  sha256_work_feeder #(.NONCE_STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
    .job_midstate(job_midstate), .job_merkle_tail(job_merkle_tail), .job_time(job_time),
    .job_bits(job_bits), .job_nonce_start(job_nonce_start), .job_nonce_end(job_nonce_end),
    .en(en), .abort(abort), .valid_o(valid_o),
    .init_0(init_w[0]), .init_1(init_w[1]), .init_2(init_w[2]), .init_3(init_w[3]),
    .init_4(init_w[4]), .init_5(init_w[5]), .init_6(init_w[6]), .init_7(init_w[7]),
    .chunk_0(chunk_w[0]), .chunk_1(chunk_w[1]), .chunk_2(chunk_w[2]), .chunk_3(chunk_w[3]),
    .chunk_4(chunk_w[4]), .chunk_5(chunk_w[5]), .chunk_6(chunk_w[6]), .chunk_7(chunk_w[7]),
    .chunk_8(chunk_w[8]), .chunk_9(chunk_w[9]), .chunk_10(chunk_w[10]), .chunk_11(chunk_w[11]),
    .chunk_12(chunk_w[12]), .chunk_13(chunk_w[13]), .chunk_14(chunk_w[14]), .chunk_15(chunk_w[15]),
    .nonce_o(nonce_o), .done_o(done_o), .aborted_o(aborted_o), .issued_cnt(issued_cnt)
  );

  sha256_work_feeder #(.NONCE_STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(r4),
    .job_midstate(job_midstate), .job_merkle_tail(job_merkle_tail), .job_time(job_time),
    .job_bits(job_bits), .job_nonce_start(job_nonce_start), .job_nonce_end(job_nonce_end),
    .en(en), .abort(abort), .valid_o(v4),
    .init_0(i4[0]), .init_1(i4[1]), .init_2(i4[2]), .init_3(i4[3]),
    .init_4(i4[4]), .init_5(i4[5]), .init_6(i4[6]), .init_7(i4[7]),
    .chunk_0(c4[0]), .chunk_1(c4[1]), .chunk_2(c4[2]), .chunk_3(c4[3]),
    .chunk_4(c4[4]), .chunk_5(c4[5]), .chunk_6(c4[6]), .chunk_7(c4[7]),
    .chunk_8(c4[8]), .chunk_9(c4[9]), .chunk_10(c4[10]), .chunk_11(c4[11]),
    .chunk_12(c4[12]), .chunk_13(c4[13]), .chunk_14(c4[14]), .chunk_15(c4[15]),
    .nonce_o(n4), .done_o(d4), .aborted_o(a4), .issued_cnt(cnt4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic set_job(input logic [31:0] s, input logic [31:0] e);
    job_midstate    = {$urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom(), $urandom()};
    job_merkle_tail = $urandom();
    job_time        = $urandom();
    job_bits        = $urandom();
    job_nonce_start = s;
    job_nonce_end   = e;
  endtask

  // Run with the current en until done_o is seen (or the bound expires), logging issues.
  task automatic run_collect(input int max_k);
    got_q.delete();
    done_k_q.delete();
    first_k = 0;
    for (int k = 1; k <= max_k && done_k_q.size() == 0; k++) begin
      tick();
      if (o_v) begin
        if (got_q.size() == 0) first_k = k;
        got_q.push_back(o_n);
      end
      if (o_d) done_k_q.push_back(k);
    end
    check("done_seen", 64'(done_k_q.size()), 64'd1);
  endtask

  vec_t        vecs [6];
  logic [63:0] cnt_before;
  logic [63:0] m_cur, m_end, m_cnt;
  logic [31:0] s, e, exp_n;
  int          ph, bad, mode;
  logic        e_v, e_d, seen104, exp_rdy_run;

  initial begin
    vecs[0] = '{32'd0,        32'd3,        4, 32'd0,        32'd3,        5};
    vecs[1] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 2, 32'hFFFFFFFE, 32'hFFFFFFFF, 3};
    vecs[2] = '{32'd5,        32'd4,        0, 32'd0,        32'd0,        2};
    vecs[3] = '{32'd7,        32'd7,        1, 32'd7,        32'd7,        2};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2};
    vecs[5] = '{32'h12345678, 32'h1234567C, 5, 32'h12345678, 32'h1234567C, 6};
`ifdef SHA256_FEEDER_JOB_QUEUE_EN
    exp_rdy_run = 1'b1;
`else
    exp_rdy_run = 1'b0;
`endif

    rst_n = 1'b0; job_valid = 1'b0; en = 1'b0; abort = 1'b0;
    set_job(32'd0, 32'd0);
    tick();
    tick();
    check("rst_valid", valid_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_aborted", aborted_o, 1'b0);
    check("rst_cnt", issued_cnt, 64'd0);
    check("rst_nonce", nonce_o, 32'd0);
    check("rst_chunk4", chunk_w[4], 32'd0);
    check("rst_ready", job_ready, 1'b0);
    rst_n = 1'b1;
    tick();
    check("rel_ready", job_ready, 1'b1);
    check("rel_ready4", r4, 1'b1);

    // Directed vector table, STEP=1, en held high.
    en = 1'b1;
    foreach (vecs[v]) begin
      cnt_before = issued_cnt;
      set_job(vecs[v].start, vecs[v].stop);
      job_valid = 1'b1;
      tick();
      job_valid = 1'b0;
      check("acc_valid", valid_o, 1'b0);
      check("acc_ready", job_ready, exp_rdy_run);
      check("pad_c4", chunk_w[4], 32'h80000000);
      check("pad_c15", chunk_w[15], 32'h00000280);
      check("tail_c0", chunk_w[0], job_merkle_tail);
      check("tail_c1", chunk_w[1], job_time);
      check("tail_c2", chunk_w[2], job_bits);
      bad = 0;
      for (int i = 5; i < 15; i++) if (chunk_w[i] != 32'd0) bad++;
      check("pad_zero", 64'(bad), 64'd0);
      for (int i = 0; i < 8; i++) check("init_word", init_w[i], job_midstate[255-32*i -: 32]);
      run_collect(40);
      check("vec_count", 64'(got_q.size()), 64'(vecs[v].n_exp));
      check("vec_done_k", 64'(done_k_q.size() > 0 ? done_k_q[0] : 0), 64'(vecs[v].done_k));
      check("vec_aborted", aborted_o, 1'b0);
      check("vec_cnt", issued_cnt, cnt_before + 64'(vecs[v].n_exp));
      check("vec_ready_done", job_ready, 1'b1);
      if (vecs[v].n_exp > 0 && got_q.size() > 0) begin
        check("vec_first_k", 64'(first_k), 64'd1);
        check("vec_first", got_q[0], vecs[v].first);
        check("vec_last", got_q[got_q.size()-1], vecs[v].last);
        bad = 0;
        for (int i = 1; i < got_q.size(); i++) if (got_q[i] != got_q[i-1] + 32'd1) bad++;
        check("vec_contig", 64'(bad), 64'd0);
      end
      tick();
      check("vec_done_once", done_o, 1'b0);
      check("vec_no_extra", valid_o, 1'b0);
    end

    // STEP=4 with an end that is not on the step grid.
    do_reset();
    sel4 = 1'b1;
    set_job(32'd1, 32'd10);
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    run_collect(20);
    check("step_count", 64'(got_q.size()), 64'd3);
    if (got_q.size() == 3) begin
      check("step_n0", got_q[0], 32'd1);
      check("step_n1", got_q[1], 32'd5);
      check("step_n2", got_q[2], 32'd9);
    end
    check("step_cnt", cnt4, 64'd3);
    check("step_aborted", o_a, 1'b0);
    for (int i = 0; i < 8; i++) check("step_init", i4[i], job_midstate[255-32*i -: 32]);
    for (int i = 0; i < 16; i++) begin
      case (i)
        0: exp_n = job_merkle_tail;
        1: exp_n = job_time;
        2: exp_n = job_bits;
        3: exp_n = 32'd9;
        4: exp_n = 32'h80000000;
        15: exp_n = 32'h00000280;
        default: exp_n = 32'd0;
      endcase
      check("step_chunk", c4[i], exp_n);
    end
    sel4 = 1'b0;

    // Throttle every other cycle, then abort right after nonce 104.
    do_reset();
    set_job(32'd100, 32'd200);
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    exp_n = 32'd100;
    seen104 = 1'b0;
    for (int k = 0; k < 40 && !seen104; k++) begin
      en = (k % 2 == 0);
      tick();
      check("thr_valid", valid_o, en);
      if (valid_o) begin
        check("thr_nonce", nonce_o, exp_n);
        if (nonce_o == 32'd104) seen104 = 1'b1;
        exp_n = exp_n + 32'd1;
      end
    end
    check("thr_reached_104", seen104, 1'b1);
    abort = 1'b1;
    en = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_no_issue", valid_o, 1'b0);
    check("abort_no_done_yet", done_o, 1'b0);
    tick();
    check("abort_done", done_o, 1'b1);
    check("abort_flag", aborted_o, 1'b1);
    check("abort_valid", valid_o, 1'b0);
    check("abort_cnt", issued_cnt, 64'd5);
    tick();
    check("abort_done_once", done_o, 1'b0);
    check("abort_flag_clr", aborted_o, 1'b0);

    // Reset in the middle of a running job.
    set_job(32'd0, 32'd1000);
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", valid_o, 1'b0);
    check("mid_rst_nonce", nonce_o, 32'd0);
    check("mid_rst_c3", chunk_w[3], 32'd0);
    check("mid_rst_c15", chunk_w[15], 32'd0);
    check("mid_rst_init0", init_w[0], 32'd0);
    check("mid_rst_cnt", issued_cnt, 64'd0);
    check("mid_rst_ready", job_ready, 1'b0);
    check("mid_rst_done", done_o, 1'b0);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", job_ready, 1'b1);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (done_o || valid_o) bad++;
      tick();
    end
    check("post_rst_quiet", 64'(bad), 64'd0);

`ifdef SHA256_FEEDER_JOB_QUEUE_EN
    // Job B queued behind A starts on the cycle right after A's last nonce.
    do_reset();
    en = 1'b1;
    set_job(32'd0, 32'd3);
    job_valid = 1'b1;
    tick();
    check("q_ready_run", job_ready, 1'b1);
    set_job(32'd50, 32'd51);
    got_q.delete();
    done_k_q.delete();
    first_k = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      job_valid = 1'b0;
      if (valid_o) begin
        if (got_q.size() == 0) first_k = k;
        got_q.push_back(nonce_o);
      end
      if (done_o) done_k_q.push_back(k);
    end
    check("q_count", 64'(got_q.size()), 64'd6);
    check("q_first_k", 64'(first_k), 64'd1);
    if (got_q.size() == 6) begin
      check("q_n3", got_q[3], 32'd3);
      check("q_n4", got_q[4], 32'd50);
      check("q_n5", got_q[5], 32'd51);
    end
    check("q_done_cnt", 64'(done_k_q.size()), 64'd2);
    if (done_k_q.size() == 2) begin
      check("q_done_a", 64'(done_k_q[0]), 64'd5);
      check("q_done_b", 64'(done_k_q[1]), 64'd7);
    end
    check("q_cnt", issued_cnt, 64'd6);
`endif

    // Random jobs against a range-sweep model.
    do_reset();
    m_cnt = 64'd0;
    for (int j = 0; j < 60; j++) begin
      mode = int'($urandom_range(0, 3));
      case (mode)
        0: begin
          s = $urandom();
          m_end = 64'(s) + 64'($urandom_range(0, 12));
          e = (m_end > 64'hFFFFFFFF) ? 32'hFFFFFFFF : m_end[31:0];
        end
        1: begin
          s = 32'hFFFFFFFF - $urandom_range(0, 5);
          e = 32'hFFFFFFFF;
        end
        2: begin
          s = $urandom_range(10, 1000);
          e = s - $urandom_range(1, 5);
        end
        default: begin
          s = $urandom();
          e = s;
        end
      endcase
      set_job(s, e);
      job_valid = 1'b1;
      tick();
      job_valid = 1'b0;
      check("rnd_acc_valid", valid_o, 1'b0);
      m_cur = 64'(s);
      m_end = 64'(e);
      ph = 1;
      for (int c = 0; c < 100 && ph != 0; c++) begin
        en = ($urandom_range(0, 3) != 0);
        e_v = 1'b0;
        e_d = 1'b0;
        exp_n = 32'd0;
        if (ph == 1) begin
          if (m_cur > m_end) ph = 2;
          else if (en) begin
            e_v = 1'b1;
            exp_n = m_cur[31:0];
            m_cnt = m_cnt + 64'd1;
            m_cur = m_cur + 64'd1;
            if (m_cur > m_end) ph = 2;
          end
        end else begin
          e_d = 1'b1;
          ph = 0;
        end
        tick();
        check("rnd_valid", valid_o, e_v);
        if (e_v) check("rnd_nonce", nonce_o, exp_n);
        check("rnd_done", done_o, e_d);
        if (e_d) check("rnd_aborted", aborted_o, 1'b0);
        check("rnd_ready", job_ready, (ph == 0) ? 1'b1 : exp_rdy_run);
      end
      check("rnd_term", 64'(ph), 64'd0);
      check("rnd_cnt", issued_cnt, m_cnt);
      if ($urandom_range(0, 2) == 0) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
